uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Shares one UART transmitter byte stream among N_REQ requesters, e.g. a debug console, a status reporter and a command responder. Packets are granted in round-robin order, and a grant is held until end-of-packet, a burst limit or an idle timeout. The block sits between the requesters and the UART TX serializer's byte input, so packets from different sources never interleave mid-packet on the line.

## Interface
- N_REQ, 4: number of requesters, 2..8.
- MAX_BURST, 16: maximum bytes per grant before forced release, 1..255.
- IDLE_TMO, 1024: cycles a granted requester may hold valid low before the grant is revoked, 1..65535.
- rstn  in  1  asynchronous active-low reset.
- clk  in  1  single clock domain; all logic is synchronous to its rising edge.
- req_valid  in  N_REQ  per-requester byte valid.
- req_data  in  N_REQ x 8  per-requester byte.
- req_last  in  N_REQ  marks the final byte of a packet.
- req_ready  out  N_REQ  per-requester accept; at most one bit is high.
- tx_valid  out  1  output byte valid, toward the serializer.
- tx_data  out  8  output byte.
- tx_ready  in  1  serializer accepts the byte.
- tx_src  out  3  index of the requester that owns tx_data.

## Operation
- Transfer rules:
  - Requester side: a byte transfers when req_valid[i] & req_ready[i].
  - Output side: a byte transfers when tx_valid & tx_ready.
- FSM states: S_IDLE, S_TAG (only when the tag feature is compiled in), S_PASS.
- S_IDLE arbitration:
  - Candidate order is ptr, ptr+1, … (mod N_REQ). The first i with req_valid[i] high becomes the grant g.
  - ptr is updated to g+1 mod N_REQ.
  - Next state is S_TAG when the tag feature is compiled in, otherwise S_PASS.
  - The burst counter and the timeout counter are cleared.
- S_PASS:
  - req_ready[g] = !tx_valid | tx_ready. No other ready bit is ever high.
  - An accepted byte loads the output register (tx_data, tx_src = g, tx_valid = 1) and increments the burst counter.
- Grant release, return to S_IDLE on the same cycle as:
  - acceptance of a byte with req_last[g] = 1; or
  - acceptance of byte number MAX_BURST, with the remainder of the packet continuing at g's next turn; or
  - the timeout counter reaching IDLE_TMO.
- Timeout counter:
  - Counts cycles in S_PASS with req_valid[g] low.
  - Cleared on every accepted byte.
  - Saturating, 16 bits.
- The output register drains independently of the FSM. A pending byte may still be waiting on tx_ready while arbitration proceeds in S_IDLE.
- Simultaneous drain and load: when tx_ready is high and a new byte is accepted in the same cycle, tx_valid stays 1 and tx_data takes the new byte.
- Requester i asserts valid while not granted: req_ready[i] stays 0 and its data is held by the requester.
- Reset asserted mid-packet: the output register is cleared (the pending byte is lost), the FSM goes to S_IDLE and ptr goes to 0. Packet recovery is the requester's responsibility.

## Timing
- Reset values: req_ready = 0, tx_valid = 0, tx_data = 0x00, tx_src = 0, state = S_IDLE, ptr = 0, counters = 0.
- Latency: a byte accepted at edge k appears on tx_valid/tx_data after edge k.
- Arbitration costs one cycle in S_IDLE. The first req_ready of a grant is high in the cycle after S_IDLE.
- Throughput: one byte per cycle when tx_ready stays high. Each grant adds 1 cycle (S_IDLE), or 2 cycles when tags are enabled.
- tx_valid, once asserted, stays high with stable tx_data/tx_src until tx_ready is sampled high.

## Configuration
- Macro: UART_ARB_TAG_EN.
- Defined:
  - After arbitration, S_TAG loads the output register with the tag byte 0xA0 | g (when the register is free), then goes to S_PASS.
  - The tag does not count toward MAX_BURST.
  - A burst-limit release produces a fresh tag at the next grant.
- Undefined: S_TAG does not exist, and S_IDLE goes directly to S_PASS.

## Structure
- Package uart_arb_pkg holds:
  - the state enum typedef (S_IDLE, S_TAG, S_PASS);
  - TAG_BASE = 8'hA0;
  - the source-index width constant SRC_W = 3.
- Sub-module uart_arb_rr_pick: combinational round-robin picker.
  - Inputs: valid vector, ptr.
  - Outputs: hit, index.
- The top level holds the FSM, the counters and the output register.

## Test plan
- Single source, tags off: req0 sends 0x11, 0x22, 0x33 (last on 0x33) with tx_ready held at 1 → tx_data shows 0x11, 0x22, 0x33 on consecutive cycles, tx_src = 0, FSM back in S_IDLE after 0x33.
- Round-robin, tags off: req1 and req3 each hold a 2-byte packet starting at the same cycle with ptr = 0 → req1's packet appears in full, then req3's; a new req0 packet is served after req3.
- Burst limit, MAX_BURST = 4: req2 sends a 6-byte packet while req0 is also valid → bytes 1–4 from req2, then req0's packet, then req2 bytes 5–6.
- Backpressure: tx_ready held at 0 for 10 cycles with req0 valid → tx_valid = 1 with tx_data stable throughout, req_ready[0] = 0, and no byte lost or duplicated after tx_ready rises.
- Timeout, IDLE_TMO = 8: req1 is granted, sends 1 byte without last, then drops valid → grant released 8 cycles later and a waiting req2 is served.
- UART_ARB_TAG_EN: req3 packet 0x55, 0x66 → tx stream 0xA3, 0x55, 0x66; rstn pulsed mid-packet → tx_valid = 0, ptr = 0.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART TX byte-stream arbiter.
// The optional tag state is compiled in by UART_ARB_TAG_EN.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TAG  = 2'd1,
    S_PASS = 2'd2
  } arb_state_t;

  localparam logic [7:0]  TAG_BASE = 8'hA0;
  localparam int unsigned SRC_W    = 3;

endpackage

// File: rtl/uart_arb_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after ptr.
module uart_arb_rr_pick
  import uart_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [SRC_W-1:0] ptr,
  output logic             hit,
  output logic [SRC_W-1:0] index
);

  logic [N_REQ-1:0] rotated;
  logic [SRC_W:0]   cand;

  always_comb begin
    // rotated[k] is requester (ptr + k) mod N_REQ
    rotated = N_REQ'({valid, valid} >> ptr);
    hit     = 1'b0;
    index   = '0;
    cand    = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (!hit && rotated[k]) begin
        hit  = 1'b1;
        cand = {1'b0, ptr} + (SRC_W+1)'(k);
        if (cand >= (SRC_W+1)'(N_REQ)) cand = cand - (SRC_W+1)'(N_REQ);
        index = cand[SRC_W-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter feeding one UART TX serializer byte input.
// Define UART_ARB_TAG_EN to emit a 0xA0|src tag byte at the start of each grant.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned MAX_BURST = 16,
  parameter int unsigned IDLE_TMO  = 1024
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [N_REQ-1:0][7:0] req_data,
  input  logic [N_REQ-1:0]      req_last,
  output logic [N_REQ-1:0]      req_ready,
  output logic                  tx_valid,
  output logic [7:0]            tx_data,
  input  logic                  tx_ready,
  output logic [SRC_W-1:0]      tx_src
);

  arb_state_t       state;
  logic [SRC_W-1:0] ptr, gnt, pick_idx, ptr_next;
  logic             pick_hit;
  logic [7:0]       burst_cnt;
  logic [15:0]      tmo_cnt;
  logic             g_valid, g_last;
  logic [7:0]       g_data;
  logic             can_load, accept, burst_end, tmo_end;

  uart_arb_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .valid (req_valid),
    .ptr   (ptr),
    .hit   (pick_hit),
    .index (pick_idx)
  );

  always_comb begin
    g_valid   = 1'b0;
    g_last    = 1'b0;
    g_data    = '0;
    req_ready = '0;
    can_load  = !tx_valid || tx_ready;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (gnt == SRC_W'(i)) begin
        g_valid      = req_valid[i];
        g_last       = req_last[i];
        g_data       = req_data[i];
        req_ready[i] = (state == S_PASS) && can_load;
      end
    end
    accept    = (state == S_PASS) && can_load && g_valid;
    burst_end = (burst_cnt == 8'(MAX_BURST - 1));
    tmo_end   = !g_valid && (tmo_cnt == 16'(IDLE_TMO - 1));
    ptr_next  = (pick_idx == SRC_W'(N_REQ - 1)) ? '0 : pick_idx + SRC_W'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_IDLE;
      ptr       <= '0;
      gnt       <= '0;
      burst_cnt <= '0;
      tmo_cnt   <= '0;
      tx_valid  <= 1'b0;
      tx_data   <= '0;
      tx_src    <= '0;
    end else begin
      // Output register drains on its own; a load below overrides the clear.
      if (tx_valid && tx_ready) tx_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pick_hit) begin
            gnt       <= pick_idx;
            ptr       <= ptr_next;
            burst_cnt <= '0;
            tmo_cnt   <= '0;
`ifdef UART_ARB_TAG_EN
            state     <= S_TAG;
`else
            state     <= S_PASS;
`endif
          end
        end
`ifdef UART_ARB_TAG_EN
        S_TAG: begin
          if (can_load) begin
            tx_valid <= 1'b1;
            tx_data  <= TAG_BASE | 8'(gnt);
            tx_src   <= gnt;
            state    <= S_PASS;
          end
        end
`endif
        S_PASS: begin
          if (accept) begin
            tx_valid  <= 1'b1;
            tx_data   <= g_data;
            tx_src    <= gnt;
            burst_cnt <= burst_cnt + 8'd1;
            tmo_cnt   <= '0;
            if (g_last || burst_end) state <= S_IDLE;
          end else begin
            if (!g_valid && (tmo_cnt != '1)) tmo_cnt <= tmo_cnt + 16'd1;
            if (tmo_end) state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: per-requester byte queues, output scoreboard.
// Expectations follow UART_ARB_TAG_EN when the bench is built with it.
module tb_uart_tx_arbiter;

  localparam int unsigned N = 4;
`ifdef UART_ARB_TAG_EN
  localparam bit TAG_EN = 1'b1;
`else
  localparam bit TAG_EN = 1'b0;
`endif
  localparam int         TMO_GAP  = 10 + int'(TAG_EN);
  localparam logic [7:0] BP_FIRST = TAG_EN ? 8'hA0 : 8'h71;

  typedef struct packed { logic [7:0] d; logic l; } item_t;
  typedef struct packed { logic [2:0] src; logic [7:0] d; } exp_t;
  typedef struct packed { logic [3:0] mask; logic [2:0] n; logic [11:0] order; } vec_t;

  logic                 clk = 1'b0;
  logic                 rstn = 1'b0;
  logic [N-1:0]         req_valid = '0;
  logic [N-1:0][7:0]    req_data = '0;
  logic [N-1:0]         req_last = '0;
  logic [N-1:0]         req_ready;
  logic                 tx_valid;
  logic [7:0]           tx_data;
  logic                 tx_ready = 1'b1;
  logic [2:0]           tx_src;

  item_t srcq[N][$];
  exp_t  expq[$];
  int    xcyc[$];
  int    first_acc[N];
  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  vec_t  vecs[7];

  uart_tx_arbiter #(.N_REQ(4), .MAX_BURST(4), .IDLE_TMO(8)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .tx_src    (tx_src)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic add_byte(input int s, input logic [7:0] d, input logic l);
    srcq[s].push_back('{d, l});
  endtask

  task automatic exp_b(input int s, input logic [7:0] d);
    expq.push_back('{3'(s), d});
  endtask

  task automatic exp_tag(input int s);
    if (TAG_EN) expq.push_back('{3'(s), 8'hA0 | 8'(s)});
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (srcq[i].size() > 0) begin
        req_valid[i] = 1'b1;
        req_data[i]  = srcq[i][0].d;
        req_last[i]  = srcq[i][0].l;
      end else begin
        req_valid[i] = 1'b0;
        req_data[i]  = '0;
        req_last[i]  = 1'b0;
      end
    end
  endtask

  function automatic bit srcs_empty();
    bit e = 1'b1;
    for (int i = 0; i < N; i++) if (srcq[i].size() > 0) e = 1'b0;
    return e;
  endfunction

  // Called at a falling edge; samples handshakes just before the next rising edge.
  task automatic step();
    item_t it;
    exp_t  e;
    #4;
    cyc++;
    chk("ready_onehot", 32'($countones(req_ready) <= 1), 1);
    for (int i = 0; i < N; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        if (first_acc[i] < 0) first_acc[i] = cyc;
        it = srcq[i].pop_front();
      end
    end
    if (tx_valid && tx_ready) begin
      xcyc.push_back(cyc);
      if (expq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_tx: got src=%0d data=%02h want nothing", tx_src, tx_data);
      end else begin
        e = expq.pop_front();
        chk("tx_src", 32'(tx_src), 32'(e.src));
        chk("tx_data", 32'(tx_data), 32'(e.d));
      end
    end
    @(negedge clk);
    drive();
  endtask

  task automatic run_drain(input string name, input int limit);
    int k = 0;
    while (!(expq.size() == 0 && srcs_empty() && !tx_valid) && k < limit) begin
      step();
      k++;
    end
    chk(name, 32'(expq.size() == 0 && srcs_empty() && !tx_valid), 1);
  endtask

  task automatic clear_trk();
    cyc = 0;
    xcyc.delete();
    for (int i = 0; i < N; i++) first_acc[i] = -1;
  endtask

  task automatic flush();
    for (int i = 0; i < N; i++) srcq[i].delete();
    expq.delete();
    drive();
  endtask

  task automatic reset_dut();
    rstn = 1'b0;
    flush();
    @(negedge clk);
    rstn = 1'b1;
    clear_trk();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{4'b0001, 3'd1, 12'(0)};
    vecs[1] = '{4'b1111, 3'd4, {3'd0, 3'd3, 3'd2, 3'd1}};
    vecs[2] = '{4'b1001, 3'd2, {6'd0, 3'd0, 3'd3}};
    vecs[3] = '{4'b0110, 3'd2, {6'd0, 3'd2, 3'd1}};
    vecs[4] = '{4'b0101, 3'd2, {6'd0, 3'd2, 3'd0}};
    vecs[5] = '{4'b1000, 3'd1, {9'd0, 3'd3}};
    vecs[6] = '{4'b1010, 3'd2, {6'd0, 3'd3, 3'd1}};

    clear_trk();
    @(negedge clk);
    chk("rst_tx_valid", 32'(tx_valid), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_tx_src", 32'(tx_src), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    rstn = 1'b1;

    // Round-robin table: each masked requester offers one single-byte packet.
    for (int v = 0; v < 7; v++) begin
      vec_t vr;
      vr = vecs[v];
      for (int i = 0; i < N; i++)
        if (vr.mask[i]) add_byte(i, 8'(16 * (v + 1) + i), 1'b1);
      drive();
      for (int j = 0; j < int'(vr.n); j++) begin
        int s;
        s = int'(vr.order[3*j +: 3]);
        exp_tag(s);
        exp_b(s, 8'(16 * (v + 1) + s));
      end
      run_drain("vec_drained", 40);
    end

    // Single source, back-to-back bytes.
    reset_dut();
    add_byte(0, 8'h11, 1'b0); add_byte(0, 8'h22, 1'b0); add_byte(0, 8'h33, 1'b1);
    drive();
    exp_tag(0); exp_b(0, 8'h11); exp_b(0, 8'h22); exp_b(0, 8'h33);
    run_drain("single_drained", 40);
    chk("single_consec", (xcyc.size() >= 3) ? 32'(xcyc[$] - xcyc[$-2]) : 32'hFFFF, 2);
    chk("single_idle_ready", 32'(req_ready), 0);

    // Two packets start together; req0 joins once req1 is granted.
    reset_dut();
    add_byte(1, 8'h21, 1'b0); add_byte(1, 8'h22, 1'b1);
    add_byte(3, 8'h31, 1'b0); add_byte(3, 8'h32, 1'b1);
    drive();
    step(); step();
    add_byte(0, 8'h01, 1'b0); add_byte(0, 8'h02, 1'b1);
    drive();
    exp_tag(1); exp_b(1, 8'h21); exp_b(1, 8'h22);
    exp_tag(3); exp_b(3, 8'h31); exp_b(3, 8'h32);
    exp_tag(0); exp_b(0, 8'h01); exp_b(0, 8'h02);
    run_drain("rr_drained", 60);

    // Burst limit of 4 splits req2's 6-byte packet around req0.
    reset_dut();
    for (int b = 0; b < 6; b++) add_byte(2, 8'(8'h61 + b), (b == 5));
    drive();
    step();
    add_byte(0, 8'h01, 1'b0); add_byte(0, 8'h02, 1'b1);
    drive();
    exp_tag(2);
    for (int b = 0; b < 4; b++) exp_b(2, 8'(8'h61 + b));
    exp_tag(0); exp_b(0, 8'h01); exp_b(0, 8'h02);
    exp_tag(2); exp_b(2, 8'h65); exp_b(2, 8'h66);
    run_drain("burst_drained", 80);

    // Backpressure: pending byte must stay put for 10 cycles.
    reset_dut();
    tx_ready = 1'b0;
    add_byte(0, 8'h71, 1'b0); add_byte(0, 8'h72, 1'b0); add_byte(0, 8'h73, 1'b1);
    drive();
    exp_tag(0); exp_b(0, 8'h71); exp_b(0, 8'h72); exp_b(0, 8'h73);
    step(); step();
    for (int k = 0; k < 10; k++) begin
      chk("bp_valid", 32'(tx_valid), 1);
      chk("bp_data", 32'(tx_data), 32'(BP_FIRST));
      chk("bp_ready", 32'(req_ready), 0);
      step();
    end
    tx_ready = 1'b1;
    run_drain("bp_drained", 40);

    // Idle timeout: req1 stalls after one byte, req2 waits.
    reset_dut();
    add_byte(1, 8'h81, 1'b0);
    add_byte(2, 8'h91, 1'b0); add_byte(2, 8'h92, 1'b1);
    drive();
    exp_tag(1); exp_b(1, 8'h81);
    exp_tag(2); exp_b(2, 8'h91); exp_b(2, 8'h92);
    run_drain("tmo_drained", 60);
    chk("tmo_gap", 32'(first_acc[2] - first_acc[1]), 32'(TMO_GAP));

    // Tagged packet, then reset in the middle of req2's packet.
    reset_dut();
    add_byte(3, 8'h55, 1'b0); add_byte(3, 8'h66, 1'b1);
    drive();
    exp_tag(3); exp_b(3, 8'h55); exp_b(3, 8'h66);
    run_drain("tag_drained", 40);
    tx_ready = 1'b0;
    add_byte(2, 8'hD1, 1'b0); add_byte(2, 8'hD2, 1'b0); add_byte(2, 8'hD3, 1'b1);
    drive();
    step(); step(); step();
    chk("pre_rst_valid", 32'(tx_valid), 1);
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(tx_valid), 0);
    chk("mid_rst_data", 32'(tx_data), 0);
    chk("mid_rst_src", 32'(tx_src), 0);
    chk("mid_rst_ready", 32'(req_ready), 0);
    flush();
    @(negedge clk);
    rstn = 1'b1;
    tx_ready = 1'b1;
    add_byte(0, 8'hE1, 1'b1);
    add_byte(3, 8'hF1, 1'b1);
    drive();
    exp_tag(0); exp_b(0, 8'hE1);
    exp_tag(3); exp_b(3, 8'hF1);
    run_drain("post_rst_drained", 40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
